// File: rtl/bus_protocol_monitor_if.sv
// ---------------------------------------------------------------------------
// bus_protocol_monitor_if
// Bundle of valid/ready/payload signals for a group of monitored channels.
//
// Signals:
//   valid  [num_channels]             per-channel valid (driven by source)
//   ready  [num_channels]             per-channel ready (driven by sink)
//   data   [num_channels*data_width]  payloads, channel i at [i*data_width +: data_width]
//
// Modports:
//   master   drives valid/data, observes ready
//   slave    observes valid/data, drives ready
//   monitor  observes everything (used by the protocol checker)
// ---------------------------------------------------------------------------
interface bus_protocol_monitor_if #(
    parameter int num_channels = 2,
    parameter int data_width   = 32
);
    logic [num_channels-1:0]            valid;
    logic [num_channels-1:0]            ready;
    logic [num_channels*data_width-1:0] data;

    modport master  (output valid, output data, input ready);
    modport slave   (input valid, input data, output ready);
    modport monitor (input valid, input ready, input data);
endinterface

// File: rtl/bus_protocol_monitor.sv
// ---------------------------------------------------------------------------
// bus_protocol_monitor
// Passive multi-channel valid/ready protocol checker. Each channel runs a
// small FSM that watches for: valid on the first cycle after reset (code 1),
// valid dropped before ready (code 2), payload changed while stalled (code 3)
// and stall longer than timeout_cycles (code 4). Per-channel handshake
// counters and a first-error capture are kept for post-mortem readout.
//
// Ports:
//   clock           system clock, rising edge
//   reset           asynchronous active-low reset
//   bus             monitored channels (monitor modport)
//   cnt_sel         channel index for counter readout
//   cnt_value       completed transactions on channel cnt_sel (0 if out of range)
//   err_valid       one-cycle pulse, some violation detected on the last edge
//   err_chan        lowest-index violating channel (with err_valid)
//   err_code        violation code for err_chan (with err_valid)
//   err_flags       per-channel error flags, sticky or pulsed (sticky_errors)
//   first_err_chan  channel of the first violation since reset
//   first_err_code  code of the first violation since reset, 0 = none
//   fire            OR of err_flags
// ---------------------------------------------------------------------------
module bus_protocol_monitor #(
    parameter int num_channels   = 2,
    parameter int data_width     = 32,
    parameter int timeout_cycles = 64,
    parameter int count_width    = 16,
    parameter int sticky_errors  = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    bus_protocol_monitor_if.monitor   bus,
    input  logic [3:0]                cnt_sel,
    output logic [count_width-1:0]    cnt_value,
    output logic                      err_valid,
    output logic [3:0]                err_chan,
    output logic [2:0]                err_code,
    output logic [num_channels-1:0]   err_flags,
    output logic [3:0]                first_err_chan,
    output logic [2:0]                first_err_code,
    output logic                      fire
);

    // Stall counter only needs to reach timeout_cycles; it is kept at least
    // one bit wide so the disabled (0) case still elaborates.
    localparam int STALL_W   = (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    localparam int STALL_SAT = (timeout_cycles < 1) ? 1 : timeout_cycles;
    localparam logic [STALL_W-1:0]     STALL_MAX = STALL_W'(STALL_SAT);
    localparam logic [STALL_W-1:0]     STALL_ONE = STALL_W'(1);
    localparam logic [count_width-1:0] CNT_MAX   = '1;
    localparam logic [count_width-1:0] CNT_ONE   = count_width'(1);

    localparam logic [2:0] CODE_NONE          = 3'd0;
    localparam logic [2:0] CODE_VALID_AFT_RST = 3'd1;
    localparam logic [2:0] CODE_VALID_DROPPED = 3'd2;
    localparam logic [2:0] CODE_DATA_CHANGED  = 3'd3;
    localparam logic [2:0] CODE_STALL_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {
        ST_POST_RST = 2'd0,
        ST_IDLE     = 2'd1,
        ST_WAIT     = 2'd2
    } state_t;

    state_t                  state_q [num_channels];
    state_t                  state_d [num_channels];
    logic [data_width-1:0]   cap_q   [num_channels];
    logic [data_width-1:0]   cap_d   [num_channels];
    logic [STALL_W-1:0]      stall_q [num_channels];
    logic [STALL_W-1:0]      stall_d [num_channels];
    logic [count_width-1:0]  cnt_q   [num_channels];
    logic [count_width-1:0]  cnt_d   [num_channels];
    logic [2:0]              code_d  [num_channels];
    logic [num_channels-1:0] viol_d;

    logic                    err_valid_q, err_valid_d;
    logic [3:0]              err_chan_q, err_chan_d;
    logic [2:0]              err_code_q, err_code_d;
    logic [num_channels-1:0] err_flags_q, err_flags_d;
    logic [3:0]              first_err_chan_q, first_err_chan_d;
    logic [2:0]              first_err_code_q, first_err_code_d;

    // Per-channel handshake tracking. Every channel evaluates its own FSM,
    // capture register, stall counter and counter; all detected conditions
    // mark the channel as violating, but only the highest-priority code
    // (1 > 2 > 3 > 4) is reported for it.
    always_comb begin
        for (int i = 0; i < num_channels; i++) begin
            logic                  vld, rdy, hs;
            logic                  c1, c2, c3, c4;
            logic [data_width-1:0] dat;

            vld = bus.valid[i];
            rdy = bus.ready[i];
            dat = bus.data[i*data_width +: data_width];
            hs  = 1'b0;
            c1  = 1'b0;
            c2  = 1'b0;
            c3  = 1'b0;
            c4  = 1'b0;

            state_d[i] = state_q[i];
            cap_d[i]   = cap_q[i];
            stall_d[i] = stall_q[i];
            cnt_d[i]   = cnt_q[i];

            case (state_q[i])
                ST_POST_RST, ST_IDLE: begin
                    if ((state_q[i] == ST_POST_RST) && vld) begin
                        c1 = 1'b1;
                    end
                    if (vld && rdy) begin
                        hs         = 1'b1;
                        state_d[i] = ST_IDLE;
                    end else if (vld) begin
                        state_d[i] = ST_WAIT;
                        cap_d[i]   = dat;
                        stall_d[i] = STALL_ONE;
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!vld) begin
                        c2         = 1'b1;
                        state_d[i] = ST_IDLE;
                        stall_d[i] = '0;
                    end else begin
                        // Re-capture so a single payload change flags once.
                        if (dat != cap_q[i]) begin
                            c3       = 1'b1;
                            cap_d[i] = dat;
                        end
                        if (rdy) begin
                            hs         = 1'b1;
                            state_d[i] = ST_IDLE;
                            stall_d[i] = '0;
                        end else if (stall_q[i] != STALL_MAX) begin
                            stall_d[i] = stall_q[i] + STALL_ONE;
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    stall_d[i] = '0;
                end
            endcase

            // Timeout fires only on the edge the counter first reaches the
            // limit; saturation then suppresses repeats for this stall.
            if ((timeout_cycles > 0) && (state_d[i] == ST_WAIT) &&
                (stall_d[i] == STALL_MAX) && (stall_q[i] != STALL_MAX)) begin
                c4 = 1'b1;
            end

            if (hs && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end

            if (c1) begin
                code_d[i] = CODE_VALID_AFT_RST;
            end else if (c2) begin
                code_d[i] = CODE_VALID_DROPPED;
            end else if (c3) begin
                code_d[i] = CODE_DATA_CHANGED;
            end else if (c4) begin
                code_d[i] = CODE_STALL_TIMEOUT;
            end else begin
                code_d[i] = CODE_NONE;
            end
            viol_d[i] = c1 | c2 | c3 | c4;
        end
    end

    // Error aggregation: the downward scan leaves the lowest violating
    // channel in err_chan/err_code. The first-error capture loads only while
    // it still reads "none", so it freezes until the next reset.
    always_comb begin
        err_valid_d      = |viol_d;
        err_chan_d       = 4'd0;
        err_code_d       = CODE_NONE;
        first_err_chan_d = first_err_chan_q;
        first_err_code_d = first_err_code_q;

        for (int i = num_channels - 1; i >= 0; i--) begin
            if (viol_d[i]) begin
                err_chan_d = 4'(i);
                err_code_d = code_d[i];
            end
        end

        if (sticky_errors != 0) begin
            err_flags_d = err_flags_q | viol_d;
        end else begin
            err_flags_d = viol_d;
        end

        if ((first_err_code_q == CODE_NONE) && err_valid_d) begin
            first_err_chan_d = err_chan_d;
            first_err_code_d = err_code_d;
        end
    end

    // State registers; reset drops every channel back into POST_RST and
    // clears all counters and error capture immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < num_channels; i++) begin
                state_q[i] <= ST_POST_RST;
                cap_q[i]   <= '0;
                stall_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            err_valid_q      <= 1'b0;
            err_chan_q       <= 4'd0;
            err_code_q       <= CODE_NONE;
            err_flags_q      <= '0;
            first_err_chan_q <= 4'd0;
            first_err_code_q <= CODE_NONE;
        end else begin
            for (int i = 0; i < num_channels; i++) begin
                state_q[i] <= state_d[i];
                cap_q[i]   <= cap_d[i];
                stall_q[i] <= stall_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            err_valid_q      <= err_valid_d;
            err_chan_q       <= err_chan_d;
            err_code_q       <= err_code_d;
            err_flags_q      <= err_flags_d;
            first_err_chan_q <= first_err_chan_d;
            first_err_code_q <= first_err_code_d;
        end
    end

    // Counter readout; indices past the last channel read as zero.
    always_comb begin
        cnt_value = '0;
        for (int i = 0; i < num_channels; i++) begin
            if (cnt_sel == 4'(i)) begin
                cnt_value = cnt_q[i];
            end
        end
    end

    assign err_valid      = err_valid_q;
    assign err_chan       = err_chan_q;
    assign err_code       = err_code_q;
    assign err_flags      = err_flags_q;
    assign first_err_chan = first_err_chan_q;
    assign first_err_code = first_err_code_q;
    assign fire           = |err_flags_q;

endmodule

// File: tb/tb_bus_protocol_monitor.sv
// ---------------------------------------------------------------------------
// tb_bus_protocol_monitor
// Directed bench for bus_protocol_monitor. Two instances share one bus: a
// sticky-flag instance (full checking) and a pulse-flag instance (flags only).
// Both use timeout_cycles=4 and count_width=2 so timeout and counter
// saturation are reachable in a few cycles.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bus_protocol_monitor;

    logic       clock = 1'b0;
    logic       rstN;
    logic [3:0] cntSel;

    logic [1:0] cntValue, pCntValue;
    logic       errValid, pErrValid;
    logic [3:0] errChan, pErrChan;
    logic [2:0] errCode, pErrCode;
    logic [1:0] errFlags, pErrFlags;
    logic [3:0] firstChan, pFirstChan;
    logic [2:0] firstCode, pFirstCode;
    logic       fire, pFire;

    int testsRun    = 0;
    int testsFailed = 0;

    bus_protocol_monitor_if #(.num_channels(2), .data_width(32)) bus ();

    bus_protocol_monitor #(
        .num_channels(2), .data_width(32), .timeout_cycles(4),
        .count_width(2), .sticky_errors(1)
    ) dut (
        .clock(clock), .reset(rstN), .bus(bus), .cnt_sel(cntSel),
        .cnt_value(cntValue), .err_valid(errValid), .err_chan(errChan),
        .err_code(errCode), .err_flags(errFlags), .first_err_chan(firstChan),
        .first_err_code(firstCode), .fire(fire)
    );

    bus_protocol_monitor #(
        .num_channels(2), .data_width(32), .timeout_cycles(4),
        .count_width(2), .sticky_errors(0)
    ) dutPulse (
        .clock(clock), .reset(rstN), .bus(bus), .cnt_sel(cntSel),
        .cnt_value(pCntValue), .err_valid(pErrValid), .err_chan(pErrChan),
        .err_code(pErrCode), .err_flags(pErrFlags), .first_err_chan(pFirstChan),
        .first_err_code(pFirstCode), .fire(pFire)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    // Backstop so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // One table row = inputs for one rising edge plus the outputs expected
    // right after that edge.
    typedef struct {
        logic [1:0]  v;
        logic [1:0]  r;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  sel;
        logic        eValid;
        logic [3:0]  eChan;
        logic [2:0]  eCode;
        logic [1:0]  eFlags;
        logic [1:0]  ePFlags;
        logic [2:0]  eFirst;
        logic [1:0]  eCnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(logic [1:0] v, logic [1:0] r, logic [31:0] d0,
                                   logic [31:0] d1, logic [3:0] sel, logic eValid,
                                   logic [3:0] eChan, logic [2:0] eCode,
                                   logic [1:0] eFlags, logic [1:0] ePFlags,
                                   logic [2:0] eFirst, logic [1:0] eCnt);
        vec_t t;
        t.v = v; t.r = r; t.d0 = d0; t.d1 = d1; t.sel = sel;
        t.eValid = eValid; t.eChan = eChan; t.eCode = eCode;
        t.eFlags = eFlags; t.ePFlags = ePFlags; t.eFirst = eFirst; t.eCnt = eCnt;
        return t;
    endfunction

    // Drives one set of inputs (called at a falling edge), lets one rising
    // edge happen, and returns at the following falling edge for sampling.
    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] r,
                                 input logic [31:0] d0, input logic [31:0] d1);
        bus.valid = v;
        bus.ready = r;
        bus.data  = {d1, d0};
        @(posedge clock);
        @(negedge clock);
    endtask

    // Holds reset for two cycles with the given inputs and releases it on a
    // falling edge, so the next rising edge is the first post-reset edge.
    task automatic doReset(input logic [1:0] v, input logic [31:0] d0);
        rstN      = 1'b0;
        bus.valid = v;
        bus.ready = 2'b00;
        bus.data  = {32'h0, d0};
        repeat (2) @(negedge clock);
        rstN = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        rstN      = 1'b0;
        cntSel    = 4'd0;
        bus.valid = 2'b00;
        bus.ready = 2'b00;
        bus.data  = '0;

        // Valid held high through reset release on channel 0.
        doReset(2'b01, 32'h5);
        checkOutput("t1 pre-edge err_valid", 32'(errValid), 32'd0);
        applyStimulus(2'b01, 2'b00, 32'h5, 32'h0);
        checkOutput("t1 err_valid", 32'(errValid), 32'd1);
        checkOutput("t1 err_chan", 32'(errChan), 32'd0);
        checkOutput("t1 err_code", 32'(errCode), 32'd1);
        checkOutput("t1 first_err_code", 32'(firstCode), 32'd1);
        checkOutput("t1 first_err_chan", 32'(firstChan), 32'd0);
        checkOutput("t1 fire", 32'(fire), 32'd1);
        checkOutput("t1 pulse flags", 32'(pErrFlags), 32'd1);
        applyStimulus(2'b01, 2'b01, 32'h5, 32'h0);
        checkOutput("t1 err_valid after", 32'(errValid), 32'd0);
        checkOutput("t1 sticky flags", 32'(errFlags), 32'd1);
        checkOutput("t1 fire held", 32'(fire), 32'd1);
        checkOutput("t1 pulse flags clear", 32'(pErrFlags), 32'd0);
        checkOutput("t1 pulse fire clear", 32'(pFire), 32'd0);
        checkOutput("t1 cnt ch0", 32'(cntValue), 32'd1);

        // Table of single-edge vectors: clean stall on ch1, data change and
        // drop on ch0, simultaneous violations, ready-only, change on handshake.
        //                v      r      d0     d1            sel  eV ch cd flags pfl first cnt
        vecs.push_back(mkVec(2'b00, 2'b00, 32'h0,  32'h0,        1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b10, 2'b00, 32'h0,  32'hDEADBEEF, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b10, 2'b00, 32'h0,  32'hDEADBEEF, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b10, 2'b00, 32'h0,  32'hDEADBEEF, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b10, 2'b10, 32'h0,  32'hDEADBEEF, 1, 0, 0, 0, 2'b00, 2'b00, 0, 1));
        vecs.push_back(mkVec(2'b00, 2'b00, 32'h0,  32'h0,        1, 0, 0, 0, 2'b00, 2'b00, 0, 1));
        vecs.push_back(mkVec(2'b01, 2'b00, 32'h10, 32'h0,        0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mkVec(2'b01, 2'b00, 32'h11, 32'h0,        0, 1, 0, 3, 2'b01, 2'b01, 3, 0));
        vecs.push_back(mkVec(2'b01, 2'b00, 32'h11, 32'h0,        0, 0, 0, 0, 2'b01, 2'b00, 3, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 32'h11, 32'h0,        0, 1, 0, 2, 2'b01, 2'b01, 3, 0));
        vecs.push_back(mkVec(2'b00, 2'b00, 32'h0,  32'h0,        2, 0, 0, 0, 2'b01, 2'b00, 3, 0));
        vecs.push_back(mkVec(2'b11, 2'b00, 32'h20, 32'h30,       1, 0, 0, 0, 2'b01, 2'b00, 3, 1));
        vecs.push_back(mkVec(2'b10, 2'b00, 32'h20, 32'h31,       1, 1, 0, 2, 2'b11, 2'b11, 3, 1));
        vecs.push_back(mkVec(2'b00, 2'b00, 32'h0,  32'h0,        1, 1, 1, 2, 2'b11, 2'b10, 3, 1));
        vecs.push_back(mkVec(2'b00, 2'b11, 32'h0,  32'h0,        0, 0, 0, 0, 2'b11, 2'b00, 3, 0));
        vecs.push_back(mkVec(2'b01, 2'b00, 32'h40, 32'h0,        0, 0, 0, 0, 2'b11, 2'b00, 3, 0));
        vecs.push_back(mkVec(2'b01, 2'b01, 32'h41, 32'h0,        0, 1, 0, 3, 2'b11, 2'b01, 3, 1));
        vecs.push_back(mkVec(2'b00, 2'b00, 32'h0,  32'h0,        0, 0, 0, 0, 2'b11, 2'b00, 3, 1));

        doReset(2'b00, 32'h0);
        foreach (vecs[k]) begin
            cntSel = vecs[k].sel;
            applyStimulus(vecs[k].v, vecs[k].r, vecs[k].d0, vecs[k].d1);
            checkOutput($sformatf("vec%0d err_valid", k), 32'(errValid), 32'(vecs[k].eValid));
            if (vecs[k].eValid) begin
                checkOutput($sformatf("vec%0d err_chan", k), 32'(errChan), 32'(vecs[k].eChan));
                checkOutput($sformatf("vec%0d err_code", k), 32'(errCode), 32'(vecs[k].eCode));
            end
            checkOutput($sformatf("vec%0d err_flags", k), 32'(errFlags), 32'(vecs[k].eFlags));
            checkOutput($sformatf("vec%0d pulse flags", k), 32'(pErrFlags), 32'(vecs[k].ePFlags));
            checkOutput($sformatf("vec%0d fire", k), 32'(fire), 32'(|vecs[k].eFlags));
            checkOutput($sformatf("vec%0d first_code", k), 32'(firstCode), 32'(vecs[k].eFirst));
            checkOutput($sformatf("vec%0d cnt_value", k), 32'(cntValue), 32'(vecs[k].eCnt));
        end

        // Stall timeout on channel 1: exactly one code-4 pulse on the 4th stall edge.
        doReset(2'b00, 32'h0);
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
        checkOutput("t4 idle err_valid", 32'(errValid), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(2'b10, 2'b00, 32'h0, 32'h77);
            checkOutput($sformatf("t4 stall%0d err_valid", k), 32'(errValid), 32'(k == 4));
            if (k == 4) begin
                checkOutput("t4 err_chan", 32'(errChan), 32'd1);
                checkOutput("t4 err_code", 32'(errCode), 32'd4);
            end
        end
        checkOutput("t4 first_err_chan", 32'(firstChan), 32'd1);
        checkOutput("t4 first_err_code", 32'(firstCode), 32'd4);
        checkOutput("t4 err_flags", 32'(errFlags), 32'd2);

        // Counter saturation, then asynchronous reset in the middle of a stall.
        doReset(2'b00, 32'h0);
        cntSel = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(2'b01, 2'b01, 32'(k), 32'h0);
            checkOutput($sformatf("t6 cnt after hs%0d", k), 32'(cntValue), (k < 3) ? 32'(k) : 32'd3);
        end
        applyStimulus(2'b01, 2'b00, 32'h50, 32'h0);
        applyStimulus(2'b01, 2'b00, 32'h51, 32'h0);
        checkOutput("t6 pre-reset err_valid", 32'(errValid), 32'd1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("t6 async err_valid", 32'(errValid), 32'd0);
        checkOutput("t6 async err_code", 32'(errCode), 32'd0);
        checkOutput("t6 async err_flags", 32'(errFlags), 32'd0);
        checkOutput("t6 async fire", 32'(fire), 32'd0);
        checkOutput("t6 async first_code", 32'(firstCode), 32'd0);
        checkOutput("t6 async cnt_value", 32'(cntValue), 32'd0);
        @(negedge clock);
        bus.valid = 2'b00;
        bus.ready = 2'b00;
        rstN      = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
            checkOutput($sformatf("t6 post-reset%0d err_valid", k), 32'(errValid), 32'd0);
            checkOutput($sformatf("t6 post-reset%0d fire", k), 32'(fire), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/bus_protocol_monitor.md
Name: bus_protocol_monitor

Overview:
- Parametrised, multi-channel valid/ready protocol checker for the copperv bus interfaces (i_raddr, i_rdata, d_raddr, d_rdata, d_waddr, d_wdata, d_wresp).
- Supersedes the single-check per-channel bus checker.
- Tracks each channel's handshake state and flags protocol violations: valid after reset, valid drop, payload change and stall timeout.
- Keeps per-channel transaction counters and a first-error capture. Instantiated in the simulation checker alongside the CPU, in monitor-only mode.

Parameters:
- num_channels, 2, number of monitored valid/ready channels (1..16).
- data_width, 32, payload width per channel.
- timeout_cycles, 64, maximum cycles valid may wait for ready; 0 disables the timeout check.
- count_width, 16, width of each transaction counter (saturating).
- sticky_errors, 1, 1 = err_flags hold until reset; 0 = err_flags pulse one cycle per violation.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid  input  num_channels  per-channel valid.
- ready  input  num_channels  per-channel ready.
- data  input  num_channels*data_width  payloads; channel i occupies bits [i*data_width +: data_width].
- cnt_sel  input  4  channel index for counter readout.
- cnt_value  output  count_width  completed transactions on channel cnt_sel (combinational mux of registered counters).
- err_valid  output  1  one-cycle pulse: at least one violation detected this cycle.
- err_chan  output  4  lowest-index violating channel, valid with err_valid.
- err_code  output  3  violation code for err_chan, valid with err_valid.
- err_flags  output  num_channels  per-channel error indication, behaviour set by sticky_errors.
- first_err_chan  output  4  channel of the first violation since reset.
- first_err_code  output  3  code of the first violation since reset; 0 = none.
- fire  output  1  OR of err_flags; wor-compatible with the checker fire bus.

Behaviour:
- Reset (reset=0, asynchronous): every output and internal register clears to 0. This covers counters, stall counters, channel FSMs (to POST_RST), err_*, first_err_* and cnt_value.
- Per-channel FSM states:
  - POST_RST: entered on reset; lasts exactly the first rising edge after reset deasserts.
  - IDLE: no pending transfer.
  - WAIT: valid=1, ready=0; the data value is captured.
- Transitions:
  - POST_RST: valid=1 -> code 1 (VALID_AFTER_RESET). Then go to WAIT if ready=0, else IDLE (handshake counted).
  - IDLE: valid&ready -> count++, stay IDLE. valid&!ready -> WAIT, capture data, stall_cnt=1.
  - WAIT: valid&ready -> count++, IDLE.
  - WAIT: valid&!ready -> stall_cnt++, stay WAIT.
  - WAIT: !valid -> code 2 (VALID_DROPPED), IDLE.
  - WAIT: valid and data != captured -> code 3 (DATA_CHANGED). The check applies on the handshake cycle too. Re-capture the new data so the same change flags only once.
- Timeout:
  - When stall_cnt reaches timeout_cycles in WAIT, raise code 4 (STALL_TIMEOUT) once per stall.
  - stall_cnt saturates; no repeat until the channel returns to IDLE.
  - stall_cnt width is clog2(timeout_cycles+1), minimum 1.
- Code priority within one channel in one cycle: 1 > 2 > 3 > 4. Only the highest-priority code is reported; all detected conditions still set the channel flag.
- Multiple channels violating in the same cycle:
  - err_chan/err_code report the lowest index.
  - err_flags set for every violating channel.
- Latency: violations are detected on edge N and appear on err_* registered after edge N, i.e. visible during cycle N+1.
- first_err_chan/code load on the first err_valid since reset and freeze until reset.
- Counters increment on each valid&ready edge and saturate at all-ones; no wrap.
- cnt_sel >= num_channels -> cnt_value = 0.
- ready without valid is legal and ignored.
- Reset asserted mid-transfer: all state is discarded immediately. The first post-reset cycle is checked in POST_RST again.

Test Plan:
1. num_channels=2; hold valid[0]=1 through reset release -> err_valid pulse on the cycle after the first edge, err_chan=0, err_code=1, first_err_code=1, fire=1.
2. Channel 1: valid=1, ready=0, data=0xDEADBEEF for 3 cycles, then ready=1 -> no error; cnt_sel=1 gives cnt_value=1.
3. Channel 0 in WAIT, data changes 0x10 -> 0x11 while ready=0 -> err_code=3, err_chan=0, one pulse only. Then valid drops before ready -> err_code=2 next; first_err_code stays 3.
4. timeout_cycles=4; valid[1]=1, ready=0 for 10 cycles -> single err_code=4, err_chan=1 after the 4th stall cycle; no further pulses.
5. Same-cycle violations: ch0 code 2 and ch1 code 3 -> err_chan=0, err_code=2, err_flags=2'b11.
6. count_width=2; 5 back-to-back handshakes on ch0 -> cnt_value=3 (saturated). Assert reset mid-WAIT -> all outputs 0 immediately; no spurious error after release with valid=0.
